// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Data-RAM request/acknowledge bus between the MEM-stage access
//               unit (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_wr;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_wr, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_wr, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage memory access unit. Issues the latched load/store
//               to the data RAM over a req/ack handshake, stalls the pipe
//               while the access is outstanding, formats load data and
//               presents registered write-back outputs.
//               Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned
//               halfword/word accesses trap instead of issuing).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  wire               clk,
  input  wire               rst,
  input  wire        [31:0] mem_pc,
  input  wire        [3:0]  mem_mem_op,
  input  wire        [31:0] mem_mem_addr,
  input  wire        [31:0] mem_mem_data,
  input  wire               mem_we,
  input  wire        [4:0]  mem_write_reg,
  input  wire        [31:0] mem_write_data,
  mem_access_unit_if.master bus,
  output logic              stall_req,
  output logic       [31:0] wb_pc,
  output logic              wb_we,
  output logic       [4:0]  wb_write_reg,
  output logic       [31:0] wb_write_data,
  output logic              mem_err
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  // The counter holds the number of completed ack-less WAIT cycles; the
  // TIMEOUT-th such cycle is the last one, so the abort fires when the count
  // is one short of TIMEOUT and the 8-bit counter never wraps.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [31:0]       wb_pc_q, wb_pc_d;
  logic              wb_we_q, wb_we_d;
  logic [4:0]        wb_write_reg_q, wb_write_reg_d;
  logic [31:0]       wb_write_data_q, wb_write_data_d;
  logic              mem_err_q, mem_err_d;

  logic              is_load;
  logic              is_store;
  logic              misalign;
  logic [3:0]        issue_be;
  logic [31:0]       issue_wdata;
  logic              is_load_q;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_data;

  // Decode the incoming op: class, alignment and store lane placement.
  always_comb begin
    is_load     = (mem_mem_op >= OP_LB) && (mem_mem_op <= OP_LW);
    is_store    = (mem_mem_op >= OP_SB) && (mem_mem_op <= OP_SW);
    issue_be    = 4'b1111;
    issue_wdata = mem_mem_data;
    case (mem_mem_op)
      OP_SB: begin
        issue_be    = 4'b0001 << mem_mem_addr[1:0];
        issue_wdata = {4{mem_mem_data[7:0]}};
      end
      OP_SH: begin
        issue_be    = 4'b0011 << {mem_mem_addr[1], 1'b0};
        issue_wdata = {2{mem_mem_data[15:0]}};
      end
      default: ;
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    misalign = (((mem_mem_op == OP_LH) || (mem_mem_op == OP_LHU) || (mem_mem_op == OP_SH))
                && mem_mem_addr[0])
            || (((mem_mem_op == OP_LW) || (mem_mem_op == OP_SW))
                && (mem_mem_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
  end

  // Select the addressed lane of the read word and extend it per load type.
  always_comb begin
    is_load_q = (op_q >= OP_LB) && (op_q <= OP_LW);
    load_byte = 8'h00;
    case (lane_q)
      2'd0:    load_byte = bus.dmem_rdata[7:0];
      2'd1:    load_byte = bus.dmem_rdata[15:8];
      2'd2:    load_byte = bus.dmem_rdata[23:16];
      default: load_byte = bus.dmem_rdata[31:24];
    endcase
    load_half = lane_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    load_data = bus.dmem_rdata;
    case (op_q)
      OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      OP_LBU:  load_data = {24'd0, load_byte};
      OP_LH:   load_data = {{16{load_half[15]}}, load_half};
      OP_LHU:  load_data = {16'd0, load_half};
      default: load_data = bus.dmem_rdata;
    endcase
  end

  // Next-state, stall and write-back update for the IDLE/WAIT/DONE sequence.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    op_d            = op_q;
    lane_d          = lane_q;
    addr_d          = addr_q;
    be_d            = be_q;
    wdata_d         = wdata_q;
    wr_d            = wr_q;
    wb_pc_d         = wb_pc_q;
    wb_we_d         = 1'b0;      // bubble unless a result retires this edge
    wb_write_reg_d  = wb_write_reg_q;
    wb_write_data_d = wb_write_data_q;
    mem_err_d       = 1'b0;
    stall_req       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!(is_load || is_store)) begin
          wb_pc_d         = mem_pc;
          wb_we_d         = mem_we;
          wb_write_reg_d  = mem_write_reg;
          wb_write_data_d = mem_write_data;
        end else begin
          // Hold upstream even for a trapped access so the op is still
          // presented while its DONE cycle retires it.
          stall_req = 1'b1;
          cnt_d     = 8'd0;
          if (misalign) begin
            state_d         = ST_DONE;
            mem_err_d       = 1'b1;
            wb_pc_d         = mem_pc;
            wb_write_reg_d  = mem_write_reg;
            wb_write_data_d = mem_write_data;
          end else begin
            state_d = ST_WAIT;
            op_d    = mem_mem_op;
            lane_d  = mem_mem_addr[1:0];
            addr_d  = {mem_mem_addr[ADDR_W-1:2], 2'b00};
            be_d    = issue_be;
            wdata_d = issue_wdata;
            wr_d    = is_store;
          end
        end
      end
      ST_WAIT: begin
        stall_req = 1'b1;
        // mem_* is held stable by the stall, so it is read directly here.
        if (bus.dmem_ack) begin
          state_d         = ST_DONE;
          wb_pc_d         = mem_pc;
          wb_we_d         = is_load_q ? mem_we : 1'b0;
          wb_write_reg_d  = mem_write_reg;
          wb_write_data_d = is_load_q ? load_data : mem_write_data;
        end else if (cnt_q == LAST_WAIT) begin
          state_d         = ST_DONE;
          mem_err_d       = 1'b1;
          wb_pc_d         = mem_pc;
          wb_write_reg_d  = mem_write_reg;
          wb_write_data_d = mem_write_data;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched access and write-back registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= 8'd0;
      op_q            <= 4'd0;
      lane_q          <= 2'd0;
      addr_q          <= '0;
      be_q            <= 4'd0;
      wdata_q         <= 32'd0;
      wr_q            <= 1'b0;
      wb_pc_q         <= 32'd0;
      wb_we_q         <= 1'b0;
      wb_write_reg_q  <= 5'd0;
      wb_write_data_q <= 32'd0;
      mem_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      op_q            <= op_d;
      lane_q          <= lane_d;
      addr_q          <= addr_d;
      be_q            <= be_d;
      wdata_q         <= wdata_d;
      wr_q            <= wr_d;
      wb_pc_q         <= wb_pc_d;
      wb_we_q         <= wb_we_d;
      wb_write_reg_q  <= wb_write_reg_d;
      wb_write_data_q <= wb_write_data_d;
      mem_err_q       <= mem_err_d;
    end
  end

  assign bus.dmem_req   = (state_q == ST_WAIT);
  assign bus.dmem_wr    = wr_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_be    = be_q;
  assign bus.dmem_wdata = wdata_q;

  assign wb_pc         = wb_pc_q;
  assign wb_we         = wb_we_q;
  assign wb_write_reg  = wb_write_reg_q;
  assign wb_write_data = wb_write_data_q;
  assign mem_err       = mem_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit: directed cases plus
//               randomized op mixes checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_pc;
  logic [3:0]  mem_mem_op;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_mem_data;
  logic        mem_we;
  logic [4:0]  mem_write_reg;
  logic [31:0] mem_write_data;
  logic        stall_req;
  logic [31:0] wb_pc;
  logic        wb_we;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_pc         (mem_pc),
    .mem_mem_op     (mem_mem_op),
    .mem_mem_addr   (mem_mem_addr),
    .mem_mem_data   (mem_mem_data),
    .mem_we         (mem_we),
    .mem_write_reg  (mem_write_reg),
    .mem_write_data (mem_write_data),
    .bus            (bus),
    .stall_req      (stall_req),
    .wb_pc          (wb_pc),
    .wb_we          (wb_we),
    .wb_write_reg   (wb_write_reg),
    .wb_write_data  (wb_write_data),
    .mem_err        (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stall_n;  // cycles with stall_req high
    int          req_n;    // cycles with dmem_req high
    logic [31:0] addr;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] wdata;
    bit          stable;   // dmem_* unchanged over all request cycles
    logic [31:0] pc;
    logic        we;
    logic [4:0]  rg;
    logic [31:0] data;
    logic        err;
    bit          done;
  } obs_t;

  // Load result from the architectural rules: pick lane by shifting, extend by arithmetic.
  function automatic logic [31:0] fmt_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int unsigned lane;
    logic [31:0] v;
    lane = addr % 4;
    v = rdata;
    if (op == 4'd1 || op == 4'd2) begin
      v = (rdata >> (8 * lane)) & 32'hFF;
      if (op == 4'd1 && v >= 32'd128) v = v - 32'd256;
    end else if (op == 4'd3 || op == 4'd4) begin
      v = (rdata >> (16 * (lane / 2))) & 32'hFFFF;
      if (op == 4'd3 && v >= 32'h8000) v = v - 32'h10000;
    end
    return v;
  endfunction

  // Expected observation for one op; ack_delay 0 means the RAM never answers.
  function automatic obs_t model(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [31:0] pc,
                                 input logic we, input logic [4:0] rg,
                                 input logic [31:0] wdat, input int ack_delay,
                                 input logic [31:0] rdata);
    obs_t e;
    bit ld, st, mis, tmo;
    int lane;
    ld   = (op >= 4'd1) && (op <= 4'd5);
    st   = (op >= 4'd6) && (op <= 4'd8);
    mis  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    if ((op == 4'd3 || op == 4'd4 || op == 4'd7) && (addr % 2 != 0)) mis = 1'b1;
    if ((op == 4'd5 || op == 4'd8) && (addr % 4 != 0)) mis = 1'b1;
`endif
    lane     = int'(addr % 4);
    e.stable = 1'b1;
    e.done   = 1'b1;
    e.pc     = pc;
    e.rg     = rg;
    e.addr   = addr & 32'hFFFF_FFFC;
    e.wr     = st;
    e.be     = 4'hF;
    e.wdata  = data;
    if (op == 4'd6) begin
      e.be    = 4'(32'd1 << lane);
      e.wdata = (data & 32'hFF) * 32'h0101_0101;
    end else if (op == 4'd7) begin
      e.be    = 4'(32'd3 << (2 * (lane / 2)));
      e.wdata = (data & 32'hFFFF) * 32'h0001_0001;
    end
    if (!(ld || st)) begin
      e.stall_n = 0; e.req_n = 0; e.we = we; e.data = wdat; e.err = 1'b0;
    end else if (mis) begin
      e.stall_n = 1; e.req_n = 0; e.we = 1'b0; e.data = wdat; e.err = 1'b1;
    end else begin
      tmo       = (ack_delay == 0);
      e.req_n   = tmo ? TIMEOUT : ack_delay;
      e.stall_n = 1 + e.req_n;
      e.err     = tmo;
      e.we      = (ld && !tmo) ? we : 1'b0;
      e.data    = (ld && !tmo) ? fmt_load(op, addr, rdata) : wdat;
    end
    return e;
  endfunction

  task automatic drive_nop();
    mem_mem_op = 4'd0; mem_we = 1'b0; mem_write_reg = 5'd0;
    mem_pc = 32'd0; mem_mem_addr = 32'd0; mem_mem_data = 32'd0; mem_write_data = 32'd0;
  endtask

  // Present one op at the current falling edge, play the RAM, return what was seen.
  // Returns at a falling edge where the next op may be presented.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] pc, input logic we, input logic [4:0] rg,
                        input logic [31:0] wdat, input int ack_delay, input logic [31:0] rdata,
                        input bit stray, output obs_t o);
    mem_pc = pc; mem_mem_op = op; mem_mem_addr = addr; mem_mem_data = data;
    mem_we = we; mem_write_reg = rg; mem_write_data = wdat;
    bus.dmem_rdata = rdata;
    o.stall_n = 0; o.req_n = 0; o.stable = 1'b1; o.done = 1'b0;
    o.addr = 32'd0; o.be = 4'd0; o.wr = 1'b0; o.wdata = 32'd0;
    o.pc = 32'd0; o.we = 1'b0; o.rg = 5'd0; o.data = 32'd0; o.err = 1'b0;
    for (int cyc = 0; cyc < 2 * TIMEOUT + 16; cyc++) begin
      #1;
      if (bus.dmem_req) bus.dmem_ack = ((o.req_n + 1) == ack_delay);
      else              bus.dmem_ack = stray;
      #1;
      if (bus.dmem_req) begin
        if (o.req_n == 0) begin
          o.addr = bus.dmem_addr; o.be = bus.dmem_be; o.wr = bus.dmem_wr; o.wdata = bus.dmem_wdata;
        end else if ({bus.dmem_addr, bus.dmem_be, bus.dmem_wr, bus.dmem_wdata}
                     !== {o.addr, o.be, o.wr, o.wdata}) begin
          o.stable = 1'b0;
        end
        o.req_n++;
      end
      if (stall_req) o.stall_n++;
      else begin
        o.done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (o.done) begin
      if (o.stall_n == 0) begin
        @(negedge clk);
        o.pc = wb_pc; o.we = wb_we; o.rg = wb_write_reg; o.data = wb_write_data; o.err = mem_err;
      end else begin
        o.pc = wb_pc; o.we = wb_we; o.rg = wb_write_reg; o.data = wb_write_data; o.err = mem_err;
        @(negedge clk);
      end
    end
    bus.dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_nop();
    repeat (2) @(negedge clk);
    #2;
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    n_checks++; if (bus.dmem_req !== 1'b0 || bus.dmem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_req_wr: got %b%b want 00", bus.dmem_req, bus.dmem_wr); end
    n_checks++; if ({bus.dmem_addr, bus.dmem_be, bus.dmem_wdata} !== 68'd0) begin n_fail++; $display("FAIL reset_dmem_bus: got %h %h %h want zeros", bus.dmem_addr, bus.dmem_be, bus.dmem_wdata); end
    n_checks++; if ({wb_pc, wb_we, wb_write_reg, wb_write_data} !== 70'd0) begin n_fail++; $display("FAIL reset_wb: got %h %b %0d %h want zeros", wb_pc, wb_we, wb_write_reg, wb_write_data); end
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", mem_err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    obs_t o;
    logic [3:0] op;
    run_op(4'd0, 32'h0, 32'h0, 32'h0000_0040, 1'b1, 5'd5, 32'd7, 1, 32'h0, 1'b0, o);
    n_checks++; if (o.stall_n !== 0 || o.req_n !== 0) begin n_fail++; $display("FAIL pass_nostall: got stall=%0d req=%0d want 0 0", o.stall_n, o.req_n); end
    n_checks++; if (o.data !== 32'd7 || o.we !== 1'b1 || o.rg !== 5'd5) begin n_fail++; $display("FAIL pass_wb: got data=%h we=%b reg=%0d want 7 1 5", o.data, o.we, o.rg); end
    n_checks++; if (o.pc !== 32'h40) begin n_fail++; $display("FAIL pass_pc: got %h want 00000040", o.pc); end
    // Undefined opcodes behave like NOP; a stray ack outside WAIT must not matter.
    for (int i = 0; i < 8; i++) begin
      op = (i % 2 == 0) ? 4'd0 : 4'($urandom_range(9, 15));
      run_op(op, $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom,
             1, $urandom, 1'b1, o);
      n_checks++;
      if (o.stall_n !== 0 || o.pc !== mem_pc || o.we !== mem_we || o.rg !== mem_write_reg || o.data !== mem_write_data) begin
        n_fail++; $display("FAIL pass_rand[%0d] op=%0d: got stall=%0d pc=%h we=%b reg=%0d data=%h want 0 %h %b %0d %h",
                           i, op, o.stall_n, o.pc, o.we, o.rg, o.data, mem_pc, mem_we, mem_write_reg, mem_write_data);
      end
    end
    drive_nop();
    @(negedge clk);
  endtask

  task automatic test_store_word();
    obs_t o;
    run_op(4'd8, 32'h10, 32'hDEAD_BEEF, 32'h100, 1'b1, 5'd3, 32'h1234, 2, 32'h0, 1'b0, o);
    drive_nop();
    n_checks++; if (o.done !== 1'b1) begin n_fail++; $display("FAIL sw_done: got %b want 1", o.done); end
    n_checks++; if (o.addr !== 32'h10 || o.be !== 4'b1111 || o.wr !== 1'b1) begin n_fail++; $display("FAIL sw_bus: got addr=%h be=%b wr=%b want 00000010 1111 1", o.addr, o.be, o.wr); end
    n_checks++; if (o.wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata: got %h want deadbeef", o.wdata); end
    n_checks++; if (o.stall_n !== 3) begin n_fail++; $display("FAIL sw_stall: got %0d want 3", o.stall_n); end
    n_checks++; if (o.we !== 1'b0 || o.err !== 1'b0) begin n_fail++; $display("FAIL sw_wb: got we=%b err=%b want 0 0", o.we, o.err); end
    n_checks++; if (o.stable !== 1'b1) begin n_fail++; $display("FAIL sw_stable: got %b want 1", o.stable); end
    @(negedge clk);
  endtask

  task automatic test_load_extend();
    obs_t o;
    run_op(4'd1, 32'h13, 32'h0, 32'h200, 1'b1, 5'd9, 32'h5555, 1, 32'h80FF_7F01, 1'b0, o);
    n_checks++; if (o.data !== 32'hFFFF_FF80 || o.we !== 1'b1 || o.rg !== 5'd9) begin n_fail++; $display("FAIL lb_sext: got %h we=%b reg=%0d want ffffff80 1 9", o.data, o.we, o.rg); end
    n_checks++; if (o.addr !== 32'h10 || o.be !== 4'b1111 || o.wr !== 1'b0) begin n_fail++; $display("FAIL lb_bus: got addr=%h be=%b wr=%b want 00000010 1111 0", o.addr, o.be, o.wr); end
    run_op(4'd2, 32'h13, 32'h0, 32'h204, 1'b1, 5'd9, 32'h5555, 3, 32'h80FF_7F01, 1'b0, o);
    n_checks++; if (o.data !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_zext: got %h want 00000080", o.data); end
    run_op(4'd3, 32'h12, 32'h0, 32'h208, 1'b1, 5'd0, 32'h5555, 1, 32'h80FF_7F01, 1'b0, o);
    drive_nop();
    n_checks++; if (o.data !== 32'hFFFF_80FF || o.rg !== 5'd0) begin n_fail++; $display("FAIL lh_sext: got %h reg=%0d want ffff80ff 0", o.data, o.rg); end
    @(negedge clk);
  endtask

  task automatic test_store_byte();
    obs_t o;
    run_op(4'd6, 32'h21, 32'h0000_00AB, 32'h300, 1'b0, 5'd1, 32'h0, 1, 32'h0, 1'b0, o);
    drive_nop();
    n_checks++; if (o.be !== 4'b0010 || o.addr !== 32'h20) begin n_fail++; $display("FAIL sb_be: got be=%b addr=%h want 0010 00000020", o.be, o.addr); end
    n_checks++; if (o.wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata: got %h want abababab", o.wdata); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    obs_t o;
    run_op(4'd5, 32'h44, 32'h0, 32'h400, 1'b1, 5'd7, 32'h9, 0, 32'h0, 1'b0, o);
    drive_nop();
    n_checks++; if (o.done !== 1'b1) begin n_fail++; $display("FAIL tmo_done: got %b want 1", o.done); end
    n_checks++; if (o.req_n !== TIMEOUT || o.stall_n !== TIMEOUT + 1) begin n_fail++; $display("FAIL tmo_cycles: got req=%0d stall=%0d want %0d %0d", o.req_n, o.stall_n, TIMEOUT, TIMEOUT + 1); end
    n_checks++; if (o.err !== 1'b1 || o.we !== 1'b0) begin n_fail++; $display("FAIL tmo_err: got err=%b we=%b want 1 0", o.err, o.we); end
    #2;
    n_checks++; if (mem_err !== 1'b0 || stall_req !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse: got err=%b stall=%b want 0 0", mem_err, stall_req); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    mem_mem_op = 4'd8; mem_mem_addr = 32'h80; mem_mem_data = 32'h1; mem_we = 1'b1;
    mem_write_reg = 5'd2; mem_pc = 32'h500; mem_write_data = 32'h3;
    bus.dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus.dmem_req !== 1'b1 || stall_req !== 1'b1) begin n_fail++; $display("FAIL rstw_pending: got req=%b stall=%b want 1 1", bus.dmem_req, stall_req); end
    rst = 1'b1;
    drive_nop();
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_checks++; if (bus.dmem_req !== 1'b0 || stall_req !== 1'b0) begin n_fail++; $display("FAIL rstw_cleared: got req=%b stall=%b want 0 0", bus.dmem_req, stall_req); end
    n_checks++; if (wb_we !== 1'b0 || wb_pc !== 32'd0 || mem_err !== 1'b0) begin n_fail++; $display("FAIL rstw_wb: got we=%b pc=%h err=%b want 0 0 0", wb_we, wb_pc, mem_err); end
    @(negedge clk);
  endtask

  task automatic test_misalign();
    obs_t o;
    run_op(4'd5, 32'h02, 32'h0, 32'h600, 1'b1, 5'd4, 32'h77, 1, 32'hCAFE_F00D, 1'b0, o);
    drive_nop();
`ifdef MEM_MISALIGN_TRAP_EN
    n_checks++; if (o.req_n !== 0 || o.stall_n !== 1) begin n_fail++; $display("FAIL mis_noreq: got req=%0d stall=%0d want 0 1", o.req_n, o.stall_n); end
    n_checks++; if (o.err !== 1'b1 || o.we !== 1'b0) begin n_fail++; $display("FAIL mis_err: got err=%b we=%b want 1 0", o.err, o.we); end
`else
    n_checks++; if (o.addr !== 32'h0 || o.req_n !== 1) begin n_fail++; $display("FAIL mis_addr: got addr=%h req=%0d want 00000000 1", o.addr, o.req_n); end
    n_checks++; if (o.data !== 32'hCAFE_F00D || o.err !== 1'b0) begin n_fail++; $display("FAIL mis_word: got data=%h err=%b want cafef00d 0", o.data, o.err); end
`endif
    @(negedge clk);
  endtask

  // Back-to-back and random mixes: each op starts the cycle after the previous retires.
  task automatic run_mix(input string tag, input int n, input bit mem_only);
    obs_t o, e;
    logic [3:0] op;
    logic [31:0] a, d, pc, wd, rd;
    logic we;
    logic [4:0] rg;
    int ad;
    bit stray;
    for (int i = 0; i < n; i++) begin
      op = mem_only ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
      a = $urandom; d = $urandom; pc = $urandom; wd = $urandom; rd = $urandom;
      we = 1'($urandom); rg = 5'($urandom);
      ad = $urandom_range(1, 4); stray = 1'($urandom);
      e = model(op, a, d, pc, we, rg, wd, ad, rd);
      run_op(op, a, d, pc, we, rg, wd, ad, rd, stray, o);
      n_checks++;
      if (o.done !== 1'b1 || o.stall_n !== e.stall_n || o.req_n !== e.req_n || o.err !== e.err) begin
        n_fail++; $display("FAIL %s[%0d] timing op=%0d: got done=%b stall=%0d req=%0d err=%b want 1 %0d %0d %b",
                           tag, i, op, o.done, o.stall_n, o.req_n, o.err, e.stall_n, e.req_n, e.err);
      end
      n_checks++;
      if (o.pc !== e.pc || o.we !== e.we || o.rg !== e.rg || o.data !== e.data) begin
        n_fail++; $display("FAIL %s[%0d] wb op=%0d addr=%h: got pc=%h we=%b reg=%0d data=%h want %h %b %0d %h",
                           tag, i, op, a, o.pc, o.we, o.rg, o.data, e.pc, e.we, e.rg, e.data);
      end
      if (e.req_n > 0) begin
        n_checks++;
        if (o.addr !== e.addr || o.be !== e.be || o.wr !== e.wr || o.stable !== 1'b1) begin
          n_fail++; $display("FAIL %s[%0d] bus op=%0d: got addr=%h be=%b wr=%b stable=%b want %h %b %b 1",
                             tag, i, op, o.addr, o.be, o.wr, o.stable, e.addr, e.be, e.wr);
        end
        if (e.wr) begin
          n_checks++;
          if (o.wdata !== e.wdata) begin
            n_fail++; $display("FAIL %s[%0d] wdata op=%0d: got %h want %h", tag, i, op, o.wdata, e.wdata);
          end
        end
      end
    end
    drive_nop();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_mix("b2b", 12, 1'b1);
  endtask

  task automatic test_random_mix();
    run_mix("mix", 60, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive_nop();
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'd0;
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_store_word();
    test_load_extend();
    test_store_byte();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    test_random_mix();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
